// File: rtl/iobus_timer_multi.sv
// Multi-channel timer-counter on the Otter I/O bus.
// Each channel: prescaler, reload, periodic/one-shot mode, IE and pending flag.
// Optional input capture is built when TIMER_CAPTURE_EN is defined.
module iobus_timer_multi #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRE_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100D000
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef TIMER_CAPTURE_EN
  input  logic [N_CH-1:0] cap_in,
`endif
  input  logic [31:0]     iobus_addr,
  input  logic [31:0]     iobus_out,
  input  logic            iobus_wr,
  output logic [31:0]     iobus_in,
  output logic            rd_hit,
  output logic            tc_intr
);

  localparam logic [31:0] StatusOff = 32'(16 * N_CH);

  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  ie_q, ie_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [PRE_W-1:0] pre_q [N_CH];
  logic [PRE_W-1:0] pre_d [N_CH];
  logic [PRE_W-1:0] psc_q [N_CH];
  logic [PRE_W-1:0] psc_d [N_CH];
  logic [CNT_W-1:0] reload_q [N_CH];
  logic [CNT_W-1:0] reload_d [N_CH];
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];

`ifdef TIMER_CAPTURE_EN
  logic [CNT_W-1:0] cap_q [N_CH];
  logic [CNT_W-1:0] cap_d [N_CH];
  logic [N_CH-1:0]  cap_s1_q, cap_s2_q, cap_s3_q;
  logic [N_CH-1:0]  cap_rise;
`endif

  // Address decode: offset from base, word-aligned, at or below STATUS.
  logic [31:0] off;
  logic        hit;
  logic        is_status;
  logic [1:0]  reg_sel;

  assign off       = iobus_addr - BASE_ADDR;
  assign hit       = (off[1:0] == 2'b00) && (off <= StatusOff);
  assign is_status = hit && (off == StatusOff);
  assign reg_sel   = off[3:2];
  assign rd_hit    = hit;

`ifdef TIMER_CAPTURE_EN
  // Edge detect on the synchronised capture inputs.
  assign cap_rise = cap_s2_q & ~cap_s3_q;
`endif

  // Level interrupt from registered pending and enable state.
  assign tc_intr = |(pend_q & ie_q);

  // Combinational read mux.
  always_comb begin
    iobus_in = '0;
    if (is_status) begin
      iobus_in[N_CH-1:0] = pend_q;
    end else if (hit) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (off[31:4] == 28'(c)) begin
          unique case (reg_sel)
            2'd0: begin
              iobus_in[0]         = en_q[c];
              iobus_in[1]         = mode_q[c];
              iobus_in[2]         = ie_q[c];
              iobus_in[3]         = pend_q[c];
              iobus_in[8 +: PRE_W] = pre_q[c];
            end
            2'd1: iobus_in[CNT_W-1:0] = reload_q[c];
            2'd2: iobus_in[CNT_W-1:0] = count_q[c];
            2'd3: begin
`ifdef TIMER_CAPTURE_EN
              iobus_in[CNT_W-1:0] = cap_q[c];
`endif
            end
            default: iobus_in = '0;
          endcase
        end
      end
    end
  end

  // Per-channel next state: prescaler/count progression, then bus writes override.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    ie_d     = ie_q;
    pend_d   = pend_q;
    pre_d    = pre_q;
    psc_d    = psc_q;
    reload_d = reload_q;
    count_d  = count_q;
`ifdef TIMER_CAPTURE_EN
    cap_d    = cap_q;
`endif
    for (int unsigned c = 0; c < N_CH; c++) begin : g_ch
      logic ch_sel;
      logic tick;
      logic set_ev;
      logic clr_ev;
      ch_sel = hit && !is_status && (off[31:4] == 28'(c));
      tick   = en_q[c] && (psc_q[c] == pre_q[c]);
      set_ev = 1'b0;

      if (en_q[c]) begin
        psc_d[c] = tick ? '0 : psc_q[c] + PRE_W'(1);
      end

      if (tick) begin
        if (count_q[c] != '0) begin
          count_d[c] = count_q[c] - CNT_W'(1);
        end else begin
          set_ev = 1'b1;
          if (mode_q[c]) begin
            en_d[c] = 1'b0;
          end else begin
            count_d[c] = reload_q[c];
          end
        end
      end

`ifdef TIMER_CAPTURE_EN
      // Latches the pre-tick count.
      if (cap_rise[c]) begin
        cap_d[c] = count_q[c];
        set_ev   = 1'b1;
      end
`endif

      clr_ev = (iobus_wr && ch_sel && (reg_sel == 2'd0) && iobus_out[3]) ||
               (iobus_wr && is_status && iobus_out[c]);

      if (iobus_wr && ch_sel && (reg_sel == 2'd0)) begin
        en_d[c]   = iobus_out[0];
        mode_d[c] = iobus_out[1];
        ie_d[c]   = iobus_out[2];
        pre_d[c]  = iobus_out[8 +: PRE_W];
        if (!en_q[c] && iobus_out[0]) begin
          psc_d[c] = '0;
        end
      end

      // Reload write beats a same-edge tick.
      if (iobus_wr && ch_sel && (reg_sel == 2'd1)) begin
        reload_d[c] = iobus_out[CNT_W-1:0];
        count_d[c]  = iobus_out[CNT_W-1:0];
        psc_d[c]    = '0;
      end

      // Event set beats software clear.
      if (set_ev) begin
        pend_d[c] = 1'b1;
      end else if (clr_ev) begin
        pend_d[c] = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= '0;
      mode_q   <= '0;
      ie_q     <= '0;
      pend_q   <= '0;
      pre_q    <= '{default: '0};
      psc_q    <= '{default: '0};
      reload_q <= '{default: '0};
      count_q  <= '{default: '0};
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      pre_q    <= pre_d;
      psc_q    <= psc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  // Capture registers and two-flop synchroniser plus edge-detect stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q    <= '{default: '0};
      cap_s1_q <= '0;
      cap_s2_q <= '0;
      cap_s3_q <= '0;
    end else begin
      cap_q    <= cap_d;
      cap_s1_q <= cap_in;
      cap_s2_q <= cap_s1_q;
      cap_s3_q <= cap_s2_q;
    end
  end
`endif

endmodule

// File: tb/tb_iobus_timer_multi.sv
// Directed self-checking bench for iobus_timer_multi (N_CH=4, CNT_W=32, PRE_W=8).
module tb_iobus_timer_multi;

  localparam logic [31:0] Base = 32'h1100D000;

  logic        clk;
  logic        rst_n;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic        rd_hit;
  logic        tc_intr;
`ifdef TIMER_CAPTURE_EN
  logic [3:0]  cap_in;
`endif

  int n_checks;
  int n_fail;

  iobus_timer_multi #(
    .N_CH      (4),
    .CNT_W     (32),
    .PRE_W     (8),
    .BASE_ADDR (Base)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TIMER_CAPTURE_EN
    .cap_in     (cap_in),
`endif
    .iobus_addr (iobus_addr),
    .iobus_out  (iobus_out),
    .iobus_wr   (iobus_wr),
    .iobus_in   (iobus_in),
    .rd_hit     (rd_hit),
    .tc_intr    (tc_intr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle store; returns 1ns after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    iobus_wr   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    iobus_addr = a;
    #1;
    d = iobus_in;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rd(Base + 32'h0, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL reset_csr0 got %h want %h", v, 32'h0); n_fail++;
    end
    n_checks++;
    if (tc_intr !== 1'b0) begin
      $display("FAIL reset_intr got %b want 0", tc_intr); n_fail++;
    end
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h0 || rd_hit !== 1'b1) begin
      $display("FAIL reset_status got %h hit %b want 0 hit 1", v, rd_hit); n_fail++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h4, 32'd3);
    wr(Base + 32'h0, 32'h105);
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (tc_intr !== 1'b0) begin
      $display("FAIL per_early got %b want 0", tc_intr); n_fail++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (tc_intr !== 1'b1) begin
      $display("FAIL per_rise1 got %b want 1", tc_intr); n_fail++;
    end
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h1) begin
      $display("FAIL per_status got %h want %h", v, 32'h1); n_fail++;
    end
    wr(Base + 32'h40, 32'h1);
    n_checks++;
    if (tc_intr !== 1'b0) begin
      $display("FAIL per_clear got %b want 0", tc_intr); n_fail++;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (tc_intr !== 1'b0) begin
      $display("FAIL per_gap got %b want 0", tc_intr); n_fail++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (tc_intr !== 1'b1) begin
      $display("FAIL per_rise2 got %b want 1", tc_intr); n_fail++;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h14, 32'd2);
    wr(Base + 32'h10, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL os_early got %h want %h", v, 32'h0); n_fail++;
    end
    @(posedge clk);
    #1;
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h2) begin
      $display("FAIL os_pend got %h want %h", v, 32'h2); n_fail++;
    end
    rd(Base + 32'h10, v);
    n_checks++;
    if (v !== 32'hA) begin
      $display("FAIL os_csr got %h want %h", v, 32'hA); n_fail++;
    end
    wr(Base + 32'h40, 32'h2);
    repeat (50) @(posedge clk);
    #1;
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL os_quiet got %h want %h", v, 32'h0); n_fail++;
    end
    rd(Base + 32'h18, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL os_count got %h want %h", v, 32'h0); n_fail++;
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h24, 32'd0);
    wr(Base + 32'h20, 32'h1);
    @(posedge clk);
    #1;
    iobus_addr = Base + 32'h40;
    iobus_out  = 32'h4;
    iobus_wr   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (iobus_in !== 32'h4) begin
        $display("FAIL coll_setwins[%0d] got %h want %h", i, iobus_in, 32'h4); n_fail++;
      end
    end
    iobus_wr = 1'b0;
    wr(Base + 32'h20, 32'h0);
    wr(Base + 32'h40, 32'h4);
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL coll_clear got %h want %h", v, 32'h0); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h4, 32'h20);
    wr(Base + 32'h0, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    rd(Base + 32'h8, v);
    n_checks++;
    if (v !== 32'h1D) begin
      $display("FAIL ar_precount got %h want %h", v, 32'h1D); n_fail++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd(Base + 32'h8, v);
    n_checks++;
    if (v !== 32'h0 || rd_hit !== 1'b1) begin
      $display("FAIL ar_count got %h hit %b want 0 hit 1", v, rd_hit); n_fail++;
    end
    rd(Base + 32'h4, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL ar_reload got %h want %h", v, 32'h0); n_fail++;
    end
    rd(Base + 32'h0, v);
    n_checks++;
    if (v !== 32'h0 || tc_intr !== 1'b0) begin
      $display("FAIL ar_csr got %h intr %b want 0 intr 0", v, tc_intr); n_fail++;
    end
    #2;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h0 || tc_intr !== 1'b0) begin
      $display("FAIL ar_after got %h intr %b want 0 intr 0", v, tc_intr); n_fail++;
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h14, 32'd0);
    wr(Base + 32'h10, 32'h3);
    @(posedge clk);
    #1;
    rd(Base + 32'h44 - 32'h4, v);
    n_checks++;
    if (v !== 32'h2 || rd_hit !== 1'b1) begin
      $display("FAIL dec_status got %h hit %b want 2 hit 1", v, rd_hit); n_fail++;
    end
    rd(Base + 32'h48, v);
    n_checks++;
    if (v !== 32'h0 || rd_hit !== 1'b0) begin
      $display("FAIL dec_above got %h hit %b want 0 hit 0", v, rd_hit); n_fail++;
    end
    rd(Base + 32'h42, v);
    n_checks++;
    if (rd_hit !== 1'b0) begin
      $display("FAIL dec_misalign got hit %b want 0", rd_hit); n_fail++;
    end
    wr(32'h1100C004, 32'hFF);
    wr(Base + 32'h46, 32'hF);
    wr(Base + 32'h48, 32'hFFFFFFFF);
    rd(Base + 32'h4, v);
    n_checks++;
    if (v !== 32'h0) begin
      $display("FAIL dec_alias_reload got %h want %h", v, 32'h0); n_fail++;
    end
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h2) begin
      $display("FAIL dec_alias_status got %h want %h", v, 32'h2); n_fail++;
    end
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] v;
    do_reset();
    wr(Base + 32'h34, 32'd100);
    wr(Base + 32'h30, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    rd(Base + 32'h38, v);
    n_checks++;
    if (v !== 32'd60) begin
      $display("FAIL cap_count60 got %0d want 60", v); n_fail++;
    end
    cap_in[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd(Base + 32'h3C, v);
    n_checks++;
    if (v !== 32'd0) begin
      $display("FAIL cap_early got %0d want 0", v); n_fail++;
    end
    @(posedge clk);
    #1;
    rd(Base + 32'h3C, v);
    n_checks++;
    if (v !== 32'd58) begin
      $display("FAIL cap_value got %0d want 58", v); n_fail++;
    end
    rd(Base + 32'h38, v);
    n_checks++;
    if (v !== 32'd57) begin
      $display("FAIL cap_count got %0d want 57", v); n_fail++;
    end
    rd(Base + 32'h40, v);
    n_checks++;
    if (v !== 32'h8) begin
      $display("FAIL cap_pend got %h want %h", v, 32'h8); n_fail++;
    end
    cap_in = '0;
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
`ifdef TIMER_CAPTURE_EN
    cap_in     = '0;
`endif
    #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_collision();
    test_async_reset();
    test_decode();
`ifdef TIMER_CAPTURE_EN
    test_capture();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
